// File: rtl/wb_arb_pkg.sv
// Shared widths, the register-zero constant and the side-buffer entry layout
// for the register-file write-port arbiter.
package wb_arb_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic              live;
        logic [REG_W-1:0]  addr;
        logic [DATA_W-1:0] data;
    } wb_arb_entry_t;

    // A source operand only depends on a pending write if it is not $zero.
    function automatic logic src_match(input logic [REG_W-1:0] src,
                                       input logic [REG_W-1:0] dst);
        return (src != REG_ZERO) && (src == dst);
    endfunction

endpackage

// File: rtl/wb_arb_fifo.sv
// Side-result buffer for late mul/div results: FIFO storage with per-entry
// kill-by-address and a parallel live-address match for the hazard unit.
module wb_arb_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  wb_arb_entry_t     push_entry,
    input  logic              pop,
    input  logic              kill_en,
    input  logic [REG_W-1:0]  kill_addr,
    input  logic [REG_W-1:0]  rs_addr,
    input  logic [REG_W-1:0]  rt_addr,
    output logic              full,
    output logic              empty,
    output logic              head_live,
    output logic [REG_W-1:0]  head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic              pend_hit
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             do_push;
    logic             do_pop;
    logic             match_any;

    wb_arb_entry_t mem [DEPTH];

    assign wr_idx = wr_ptr[IDX_W-1:0];
    assign rd_idx = rd_ptr[IDX_W-1:0];

    // Extra pointer MSB separates full (MSBs differ) from empty (MSBs equal).
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) && (wr_idx == rd_idx);

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head_live = !empty && mem[rd_idx].live;
    assign head_addr = mem[rd_idx].addr;
    assign head_data = mem[rd_idx].data;

    // Live bits are cleared on pop, so a set live bit always marks an occupied slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && (mem[i].addr == kill_addr)) begin
                    mem[i].live <= 1'b0;
                end
            end
            if (do_pop) begin
                mem[rd_idx].live <= 1'b0;
                rd_ptr           <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                mem[wr_idx] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        match_any = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i].live &&
                (src_match(rs_addr, mem[i].addr) || src_match(rt_addr, mem[i].addr))) begin
                match_any = 1'b1;
            end
        end
    end

    assign pend_hit = match_any && !reset;

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: WB stage has priority, buffered mul/div
// results drain into idle slots, and a starving head raises stall_req.
module wb_write_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_we,
    input  logic [REG_W-1:0]  wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              md_valid,
    input  logic [REG_W-1:0]  md_addr,
    input  logic [DATA_W-1:0] md_data,
    output logic              md_ready,
    input  logic [REG_W-1:0]  rs_addr,
    input  logic [REG_W-1:0]  rt_addr,
    output logic              pend_hit,
    output logic              stall_req,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_addr,
    output logic [DATA_W-1:0] rf_data
);

    localparam int                AGE_W     = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0]  AGE_RELOAD = AGE_W'(STARVE_LIMIT);

    logic              fifo_full;
    logic              fifo_empty;
    logic              head_live;
    logic [REG_W-1:0]  head_addr;
    logic [DATA_W-1:0] head_data;
    logic              grant_wb;
    logic              pop_live;
    logic              pop_dead;
    logic              fifo_pop;
    logic              fifo_push;
    wb_arb_entry_t     push_entry;
    logic [AGE_W-1:0]  age_left;
    logic [AGE_W-1:0]  age_left_next;

    assign md_ready  = !fifo_full && !reset;
    assign fifo_push = md_valid && md_ready;

    // A WB request to $zero writes nothing but still holds the slot.
    assign grant_wb = wb_we && (wb_addr != REG_ZERO);
    assign pop_live = head_live && !wb_we;
    assign pop_dead = !fifo_empty && !head_live && !grant_wb;
    assign fifo_pop = pop_live || pop_dead;

    // A same-cycle pipeline write to the same register supersedes the push.
    always_comb begin
        push_entry      = '0;
        push_entry.addr = md_addr;
        push_entry.data = md_data;
        push_entry.live = (md_addr != REG_ZERO) && !(grant_wb && (md_addr == wb_addr));
    end

    wb_arb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .kill_en    (grant_wb),
        .kill_addr  (wb_addr),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head_live  (head_live),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .pend_hit   (pend_hit)
    );

    // Remaining wait budget of the head; zero is the starved terminal count.
    always_comb begin
        age_left_next = age_left;
        if (fifo_empty || fifo_pop) begin
            age_left_next = AGE_RELOAD;
        end else if (head_live && (age_left != '0)) begin
            age_left_next = age_left - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            age_left  <= AGE_RELOAD;
            stall_req <= 1'b0;
        end else begin
            age_left  <= age_left_next;
            stall_req <= (age_left_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we   <= 1'b0;
            rf_addr <= '0;
            rf_data <= '0;
        end else if (grant_wb) begin
            rf_we   <= 1'b1;
            rf_addr <= wb_addr;
            rf_data <= wb_data;
        end else if (pop_live) begin
            rf_we   <= 1'b1;
            rf_addr <= head_addr;
            rf_data <= head_data;
        end else begin
            rf_we   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: expected register-file writes are queued
// with each scenario and a negedge monitor matches them against rf_we traffic.
module tb_wb_write_arbiter;
    import wb_arb_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              wb_we;
    logic [REG_W-1:0]  wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              md_valid;
    logic [REG_W-1:0]  md_addr;
    logic [DATA_W-1:0] md_data;
    logic              md_ready;
    logic [REG_W-1:0]  rs_addr;
    logic [REG_W-1:0]  rt_addr;
    logic              pend_hit;
    logic              stall_req;
    logic              rf_we;
    logic [REG_W-1:0]  rf_addr;
    logic [DATA_W-1:0] rf_data;

    typedef struct {
        logic [REG_W-1:0]  addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_checks = 0;
    int  n_fail   = 0;

    always #5 clk = ~clk;

    wb_write_arbiter #(
        .DEPTH(2),
        .STARVE_LIMIT(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .md_valid  (md_valid),
        .md_addr   (md_addr),
        .md_data   (md_data),
        .md_ready  (md_ready),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .pend_hit  (pend_hit),
        .stall_req (stall_req),
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [REG_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic we, input logic [REG_W-1:0] wa, input logic [DATA_W-1:0] wd,
                         input logic mv, input logic [REG_W-1:0] ma, input logic [DATA_W-1:0] md);
        wb_we    = we;
        wb_addr  = wa;
        wb_data  = wd;
        md_valid = mv;
        md_addr  = ma;
        md_data  = md;
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write",
                         rf_addr, rf_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(rf_addr), 32'(mon_e.addr));
                chk("wr_data", rf_data, mon_e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        rs_addr = '0;
        rt_addr = '0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        cyc;
        cyc;

        rs_addr = 5'd9;
        mid;
        chk("reset_md_ready", 32'(md_ready), 32'd0);
        chk("reset_pend_hit", 32'(pend_hit), 32'd0);
        chk("reset_rf_we", 32'(rf_we), 32'd0);
        chk("reset_rf_addr", 32'(rf_addr), 32'd0);
        chk("reset_rf_data", rf_data, 32'd0);
        chk("reset_stall", 32'(stall_req), 32'd0);
        cyc;
        reset = 1'b0;
        mid;
        chk("post_reset_md_ready", 32'(md_ready), 32'd1);
        cyc;
        rs_addr = '0;

        // pipeline write and write to $zero
        expect_wr(5'd8, 32'h1234);
        drive(1'b1, 5'd8, 32'h1234, 1'b0, 5'd0, 32'h0);
        cyc;
        drive(1'b1, 5'd0, 32'hdead, 1'b0, 5'd0, 32'h0);
        cyc;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        mid;
        chk("wb_zero_no_write", 32'(rf_we), 32'd0);
        cyc;

        // side drain: push, eligible next cycle, write the cycle after
        expect_wr(5'd9, 32'hcafe);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hcafe);
        rs_addr = 5'd9;
        cyc;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        mid;
        chk("pend_buffered", 32'(pend_hit), 32'd1);
        chk("side_not_yet", 32'(rf_we), 32'd0);
        cyc;
        mid;
        chk("pend_after_pop", 32'(pend_hit), 32'd0);
        cyc;
        rs_addr = '0;
        cyc;
        chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);

        // full buffer under continuous WB traffic, starvation, then drain
        for (int i = 1; i <= 6; i++) expect_wr(5'(i), 32'h100 + 32'(i));
        expect_wr(5'd12, 32'ha1);
        expect_wr(5'd13, 32'ha2);
        drive(1'b1, 5'd1, 32'h101, 1'b1, 5'd12, 32'ha1);
        cyc;
        drive(1'b1, 5'd2, 32'h102, 1'b1, 5'd13, 32'ha2);
        mid;
        chk("ready_one_entry", 32'(md_ready), 32'd1);
        cyc;
        drive(1'b1, 5'd3, 32'h103, 1'b1, 5'd14, 32'ha3);
        mid;
        chk("full_ready_low", 32'(md_ready), 32'd0);
        cyc;
        drive(1'b1, 5'd4, 32'h104, 1'b1, 5'd14, 32'ha3);
        rt_addr = 5'd13;
        mid;
        chk("pend_rt", 32'(pend_hit), 32'd1);
        chk("full_ready_hold", 32'(md_ready), 32'd0);
        cyc;
        drive(1'b1, 5'd5, 32'h105, 1'b1, 5'd14, 32'ha3);
        rt_addr = '0;
        mid;
        chk("stall_early", 32'(stall_req), 32'd0);
        cyc;
        drive(1'b1, 5'd6, 32'h106, 1'b1, 5'd14, 32'ha3);
        mid;
        chk("stall_set", 32'(stall_req), 32'd1);
        cyc;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        mid;
        chk("stall_hold", 32'(stall_req), 32'd1);
        chk("ready_before_pop", 32'(md_ready), 32'd0);
        cyc;
        mid;
        chk("ready_after_pop", 32'(md_ready), 32'd1);
        chk("stall_clear", 32'(stall_req), 32'd0);
        cyc;
        cyc;
        cyc;
        chk("full_sb_empty", 32'(exp_q.size()), 32'd0);

        // kill: pipeline write supersedes a buffered entry
        expect_wr(5'd10, 32'h5);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'h77);
        rs_addr = 5'd10;
        cyc;
        drive(1'b1, 5'd10, 32'h5, 1'b0, 5'd0, 32'h0);
        mid;
        chk("pend_before_kill", 32'(pend_hit), 32'd1);
        cyc;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        mid;
        chk("pend_after_kill", 32'(pend_hit), 32'd0);
        cyc;
        mid;
        chk("dead_pop_no_write", 32'(rf_we), 32'd0);
        cyc;
        rs_addr = '0;
        cyc;
        cyc;
        chk("kill_sb_empty", 32'(exp_q.size()), 32'd0);

        // simultaneous push/write to the same register, then a push to $zero
        expect_wr(5'd11, 32'h55);
        drive(1'b1, 5'd11, 32'h55, 1'b1, 5'd11, 32'h66);
        cyc;
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h99);
        rs_addr = 5'd11;
        mid;
        chk("pend_same_cycle_kill", 32'(pend_hit), 32'd0);
        cyc;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        mid;
        chk("no_stale_write", 32'(rf_we), 32'd0);
        cyc;
        mid;
        chk("no_r0_write", 32'(rf_we), 32'd0);
        cyc;
        rs_addr = '0;
        cyc;
        cyc;
        chk("simul_sb_empty", 32'(exp_q.size()), 32'd0);

        // reset while two entries are buffered
        expect_wr(5'd20, 32'h1);
        expect_wr(5'd22, 32'h2);
        drive(1'b1, 5'd20, 32'h1, 1'b1, 5'd21, 32'hb1);
        cyc;
        drive(1'b1, 5'd22, 32'h2, 1'b1, 5'd23, 32'hb2);
        cyc;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        reset   = 1'b1;
        rs_addr = 5'd21;
        mid;
        chk("midreset_md_ready", 32'(md_ready), 32'd0);
        chk("midreset_pend", 32'(pend_hit), 32'd0);
        cyc;
        reset = 1'b0;
        mid;
        chk("after_reset_rf_we", 32'(rf_we), 32'd0);
        chk("after_reset_rf_addr", 32'(rf_addr), 32'd0);
        chk("after_reset_rf_data", rf_data, 32'd0);
        chk("after_reset_stall", 32'(stall_req), 32'd0);
        chk("after_reset_md_ready", 32'(md_ready), 32'd1);
        chk("after_reset_pend", 32'(pend_hit), 32'd0);
        cyc;
        repeat (5) cyc;
        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Arbiter and scheduler for the register-file write port of the pipelined MIPS core. The WB stage owns the port by default. A multi-cycle multiply/divide unit delivers late results through a small buffer, which drains into idle write slots. The block kills buffered results superseded by younger pipeline writes, reports pending destinations to the hazard unit, and requests a bubble when a buffered result starves.

## Interface
Parameters:
- DEPTH, 2: side-result buffer entries; power of two, at least 2.
- STARVE_LIMIT, 4: cycles a live head entry may wait before stall_req asserts; at least 1.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-high.
- wb_we, in, 1: WB stage write request.
- wb_addr, in, 5: WB destination register.
- wb_data, in, 32: WB write data.
- md_valid, in, 1: mul/div result offered.
- md_addr, in, 5: mul/div destination register.
- md_data, in, 32: mul/div result.
- md_ready, out, 1: buffer can accept; equals !full && !reset.
- rs_addr, in, 5: decode-stage source register for the pending check.
- rt_addr, in, 5: decode-stage source register for the pending check.
- pend_hit, out, 1: combinational; rs or rt matches a live buffered entry.
- stall_req, out, 1: registered; asks the hazard unit for WB bubbles.
- rf_we, out, 1: registered register-file write enable.
- rf_addr, out, 5: registered write address.
- rf_data, out, 32: registered write data.

## Operation
- Buffer: DEPTH-entry FIFO. Each entry holds {live, addr, data}.
- Push: md_valid && md_ready. The entry is stored with live=1, except when md_addr==0, in which case live=0.
- No push is accepted while the buffer is full, even if a pop happens in the same cycle.
- Pipeline grant: wb_we && wb_addr!=0 always wins. Next cycle, rf_we=1 with the WB addr and data.
- wb_we to register 0: no rf write. The request still occupies the slot, so the head does not drain that cycle.
- Kill: a granted pipeline write to register R clears live on every buffered entry with addr R. It also stores a same-cycle pushed entry for R with live=0. The pipeline write always supersedes.
- Head pop, live head: pops only in a cycle with wb_we=0. Next cycle, rf_we=1 with the head addr and data.
- Head pop, dead head: pops in any cycle with no rf write, independent of wb_we.
- At most one pop per cycle.
- rf_we=0 in any cycle with no grant.
- pend_hit: (rs_addr!=0 && rs_addr matches a live entry) || (rt_addr!=0 && rt_addr matches a live entry).
- Age counter:
  - Increments each cycle the head is live and not popped.
  - Saturates at STARVE_LIMIT.
  - Clears on every pop and whenever the buffer is empty.
- stall_req: registered; 1 while age==STARVE_LIMIT.
  - The pipeline keeps priority even while stall_req=1. No data is ever lost.

## Timing
- Reset values: rf_we=0, rf_addr=0, rf_data=0, stall_req=0; buffer empty; age=0.
- md_ready=0 and pend_hit=0 while reset=1.
- Reset mid-operation discards all buffered entries without writing them.
- Pipeline latency: wb_we in cycle N gives rf_we in cycle N+1.
- Side latency, minimum: push in cycle N, head eligible in N+1, rf_we in N+2.
- Full: md_ready falls the cycle after the DEPTH-th push. It rises the cycle after the first pop.
- Pointer wrap: pointers use log2(DEPTH)+1 bits. Full/empty is decided by the MSB compare.
- pend_hit covers an entry from the cycle after its push until the cycle its pop or kill occurs, inclusive of that cycle's combinational view before the edge.

## Structure
- Package wb_arb_pkg holds:
  - REG_ZERO=0, REG_W=5, DATA_W=32.
  - The entry struct {live, addr, data}.
- Sub-module wb_arb_fifo: storage, pointers, full/empty, per-entry kill-by-address, and parallel address match for pend_hit.
- Top level: grant selection, age counter, output registers.

## Test plan
- Pipeline only: wb_we=1, wb_addr=8, wb_data=0x1234 in cycle 5 → rf_we=1, rf_addr=8, rf_data=0x1234 in cycle 6. wb_addr=0 → rf_we stays 0.
- Side drain: md push (addr 9, data 0xCAFE) in cycle 3, wb_we=0 → rf_we with addr 9, data 0xCAFE in cycle 5. pend_hit=1 with rs_addr=9 in cycle 4, and 0 in cycle 5.
- Full/backpressure: DEPTH=2, two pushes while wb_we=1 continuously → md_ready=0 after the second push. stall_req=1 after 4 waiting cycles. Drop wb_we → two side writes on consecutive cycles; md_ready returns to 1.
- Kill: buffered entry for addr 10, then pipeline write to 10 with 0x5 → rf writes 10=0x5 only. The dead entry pops with no rf_we. pend_hit for 10 drops the cycle after the kill.
- Simultaneous: push addr 11 in the same cycle as pipeline write to 11 → only the pipeline value is written. Push addr 0 → never written.
- Reset mid-drain: two entries buffered, reset pulsed for 1 cycle → all outputs zero and no side writes afterwards; md_ready=1 the cycle after reset deasserts.
